reorder_buffer: RTL and testbench
=================================

Name: reorder_buffer

Overview:
- Circular in-order retirement queue for the Tomasulo core. It sits downstream of dispatch/register rename and upstream of the register file.
- Allocates rename tags to dispatched instructions and collects results from the CDB and from the register file's simple-instruction path.
- Retires at most one instruction per cycle, in program order. Retirement drives the register-file update port, the store-commit signal, and pipeline flush on branch mispredict.

Parameters:
- ROB_DEPTH, 16, number of entries; must equal 2**TAG_W.
- TAG_W, 4, rename tag width; matches the register file rename fields.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- rdy  in  1  global enable; when 0, all state and outputs hold.
- alloc_valid  in  1  dispatch requests an entry this cycle.
- alloc_type  in  2  entry type: 0=normal, 1=simple, 2=branch, 3=store.
- alloc_dest  in  5  architectural rd; ignored for branch and store.
- alloc_pred_taken  in  1  predictor direction for a branch.
- alloc_tag  out  TAG_W  tag the next allocation will receive (equals tail).
- rob_full  out  1  count == ROB_DEPTH.
- simple_ins_commit  in  1  register file marks a simple entry done.
- simple_ins_rename  in  TAG_W  tag of that simple entry.
- simple_ins_value  in  32  result of that simple entry.
- cdb_valid  in  1  CDB broadcast is present.
- cdb_tag  in  TAG_W  tag of the CDB broadcast.
- cdb_value  in  32  rd value; for a branch, the correct next PC.
- cdb_branch_taken  in  1  actual branch direction.
- register_update_flag  out  1  one-cycle pulse that writes the register file.
- register_commit_dest  out  5  rd of the retiring entry.
- register_commit_value  out  32  value of the retiring entry.
- rename_of_commit_ins  out  TAG_W  tag of the retiring entry.
- store_commit  out  1  one-cycle pulse; the head store may write memory.
- store_commit_tag  out  TAG_W  tag of that store.
- rob_flush  out  1  one-cycle mispredict flush pulse, fanned out to register_flush and the RS/LSB.
- rob_flush_pc  out  32  redirect PC, valid while rob_flush=1.

Behaviour:
- Reset (rst=0, async):
  - head=0, tail=0, count=0; all entry busy/ready bits cleared.
  - All outputs 0. rob_full=0, alloc_tag=0.
- Storage per entry: busy, ready, type, dest, value, pred_taken, act_taken.
- Allocation:
  - Accepted when alloc_valid && !rob_full (rob_full taken from start-of-cycle state).
  - Writes the entry at tail with busy=1 and ready=0.
  - tail increments mod ROB_DEPTH.
- Writeback:
  - cdb_valid sets ready, value and act_taken at entry cdb_tag.
  - simple_ins_commit sets ready and value at entry simple_ins_rename.
  - Both may occur in the same cycle to different tags; if the tags are equal, the CDB wins.
  - Writes to a non-busy entry are ignored.
- Retire: each cycle, if count>0 and the head entry is ready, the entry retires and the outputs below are registered, so they are visible the next cycle.
  - normal/simple: register_update_flag=1, with register_commit_dest, register_commit_value and rename_of_commit_ins driven from the entry.
  - store: store_commit=1, store_commit_tag=head.
  - branch, act_taken==pred_taken: no side effect.
  - branch, act_taken!=pred_taken: rob_flush=1, rob_flush_pc=value.
  - After any retire: head increments mod ROB_DEPTH, entry busy cleared.
  - Every pulse output deasserts the cycle after it is raised unless another retire occurs.
- Latency:
  - A writeback to the head entry in cycle N causes retire in cycle N+1, with outputs visible in N+2.
  - No same-cycle bypass from writeback to retire.
- Simultaneous alloc and retire: count is unchanged; head and tail both advance.
- Full:
  - Allocation is refused while full, even if a retire happens in the same cycle.
  - The freed slot is usable the next cycle.
- Wrap-around: tail 15 -> 0 and head 15 -> 0 are handled naturally by TAG_W-bit pointers; count is TAG_W+1 bits.
- Flush (mispredict retire):
  - In the same edge: head=tail=count=0 and all busy cleared.
  - Any allocation and writebacks in that cycle are discarded.
  - The next cycle starts from an empty state, with alloc_tag=0.
- rdy=0: no state change, and outputs hold their previous values, including pulses.
- Async reset asserted mid-operation clears everything immediately; the first allocation after release gets tag 0.

Decomposition:
- Shared package rob_pkg:
  - ROB_DEPTH and TAG_W constants.
  - Entry-type encodings ROB_NORMAL, ROB_SIMPLE, ROB_BRANCH, ROB_STORE.
  - Entry struct.
- Natural sub-module: rob_ptr_ctrl, which holds head/tail/count, full/empty and the alloc/retire/flush pointer arithmetic.
- The entry array and retire mux stay in reorder_buffer.

Test Plan:
- Basic retire: alloc normal dest=5 (tag 0), then cdb_valid tag=0 value=0x1234 → two cycles later a single-cycle pulse with register_update_flag=1, dest=5, value=0x1234, rename_of_commit_ins=0.
- Out-of-order writeback:
  - Alloc tags 0,1,2.
  - CDB writes tag 2, then 1, then 0.
  - Retire pulses must appear in order 0,1,2, on consecutive cycles after tag 0 is ready.
- Full and wrap:
  - 16 allocs → rob_full=1, and a 17th alloc is ignored.
  - Retire one; the next alloc gets tag 0 again.
  - Retire through tag 15 → head wraps to 0.
- Mispredict:
  - Alloc branch pred_taken=0 (tag 0), then normal entries tags 1-3.
  - CDB tag 0 with taken=1, value=0x80.
  - Expected: rob_flush=1, rob_flush_pc=0x80; no register updates for tags 1-3; next alloc_tag=0.
- Store plus simple in the same cycle:
  - Alloc store (tag 0) and simple (tag 1).
  - In one cycle: simple_ins_commit tag=1 value=7 and cdb_valid tag=0.
  - Expected: store_commit with tag 0, then next cycle register_update_flag with value 7.
- rdy and reset:
  - Hold rdy=0 for 3 cycles with a ready head → no retire.
  - Assert rst=0 mid-stream → outputs 0 immediately; after release, first alloc gets tag 0.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared constants, entry-type encodings and the per-entry record for the
// reorder buffer.
package rob_pkg;

    localparam int TAG_W     = 4;
    localparam int ROB_DEPTH = 1 << TAG_W;

    typedef enum logic [1:0] {
        ROB_NORMAL = 2'd0,
        ROB_SIMPLE = 2'd1,
        ROB_BRANCH = 2'd2,
        ROB_STORE  = 2'd3
    } rob_type_e;

    typedef struct packed {
        logic      busy;
        logic      ready;
        rob_type_e typ;
        logic [4:0]  dest;
        logic [31:0] value;
        logic      pred_taken;
        logic      act_taken;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch, writeback and retirement signals of the reorder buffer.
// No back-pressure handshake: dispatch watches rob_full; every pulse output is valid for one cycle.
interface reorder_buffer_if;
    import rob_pkg::*;

    logic              alloc_valid;
    logic [1:0]        alloc_type;
    logic [4:0]        alloc_dest;
    logic              alloc_pred_taken;
    logic [TAG_W-1:0]  alloc_tag;
    logic              rob_full;

    logic              simple_ins_commit;
    logic [TAG_W-1:0]  simple_ins_rename;
    logic [31:0]       simple_ins_value;

    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [31:0]       cdb_value;
    logic              cdb_branch_taken;

    logic              register_update_flag;
    logic [4:0]        register_commit_dest;
    logic [31:0]       register_commit_value;
    logic [TAG_W-1:0]  rename_of_commit_ins;
    logic              store_commit;
    logic [TAG_W-1:0]  store_commit_tag;
    logic              rob_flush;
    logic [31:0]       rob_flush_pc;

    modport master (
        output alloc_valid, alloc_type, alloc_dest, alloc_pred_taken,
        output simple_ins_commit, simple_ins_rename, simple_ins_value,
        output cdb_valid, cdb_tag, cdb_value, cdb_branch_taken,
        input  alloc_tag, rob_full,
        input  register_update_flag, register_commit_dest, register_commit_value,
        input  rename_of_commit_ins, store_commit, store_commit_tag, rob_flush, rob_flush_pc
    );

    modport slave (
        input  alloc_valid, alloc_type, alloc_dest, alloc_pred_taken,
        input  simple_ins_commit, simple_ins_rename, simple_ins_value,
        input  cdb_valid, cdb_tag, cdb_value, cdb_branch_taken,
        output alloc_tag, rob_full,
        output register_update_flag, register_commit_dest, register_commit_value,
        output rename_of_commit_ins, store_commit, store_commit_tag, rob_flush, rob_flush_pc
    );

endinterface

// File: rtl/reorder_buffer_ptr_ctrl.sv
// Head/tail/count bookkeeping for the circular reorder buffer.
// alloc_i and retire_i are already qualified by the caller; flush_i wins over both.
module rob_ptr_ctrl
    import rob_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_i,
    input  logic             retire_i,
    input  logic             flush_i,
    output logic [TAG_W-1:0] head_o,
    output logic [TAG_W-1:0] tail_o,
    output logic [TAG_W:0]   count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [TAG_W:0]   count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // Pointers wrap naturally at TAG_W bits.
            if (alloc_i)  tail_d = tail_q + TAG_W'(1);
            if (retire_i) head_d = head_q + TAG_W'(1);
            count_d = count_q + (TAG_W+1)'(alloc_i) - (TAG_W+1)'(retire_i);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_o  = head_q;
    assign tail_o  = tail_q;
    assign count_o = count_q;
    assign full_o  = (count_q == (TAG_W+1)'(ROB_DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement queue: allocates rename tags, collects CDB/simple-path
// results and retires one entry per cycle into registered commit outputs.
module reorder_buffer
    import rob_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    reorder_buffer_if.slave    bus
);

    logic [TAG_W-1:0] head, tail;
    logic [TAG_W:0]   count;
    logic             full, empty;
    logic             retire, mispredict, flush, alloc_go;

    rob_entry_t entries_q [ROB_DEPTH];
    rob_entry_t entries_d [ROB_DEPTH];
    rob_entry_t head_ent;

    logic              upd_q, st_q, flush_q;
    logic [4:0]        dest_q;
    logic [31:0]       value_q, flush_pc_q;
    logic [TAG_W-1:0]  ren_q, st_tag_q;

    rob_ptr_ctrl u_ptr (
        .clk      (clk),
        .rst      (rst),
        .alloc_i  (alloc_go),
        .retire_i (retire),
        .flush_i  (flush),
        .head_o   (head),
        .tail_o   (tail),
        .count_o  (count),
        .full_o   (full),
        .empty_o  (empty)
    );

    // Retire looks only at registered readiness, so a writeback retires one cycle later.
    assign head_ent   = entries_q[head];
    assign retire     = rdy && !empty && head_ent.busy && head_ent.ready;
    assign mispredict = (head_ent.typ == ROB_BRANCH) && (head_ent.act_taken != head_ent.pred_taken);
    assign flush      = retire && mispredict;
    assign alloc_go   = rdy && bus.alloc_valid && !full && !flush;

    always_comb begin
        for (int i = 0; i < ROB_DEPTH; i++) entries_d[i] = entries_q[i];
        if (rdy) begin
            if (bus.simple_ins_commit && entries_q[bus.simple_ins_rename].busy) begin
                entries_d[bus.simple_ins_rename].ready = 1'b1;
                entries_d[bus.simple_ins_rename].value = bus.simple_ins_value;
            end
            // Applied after the simple path so the CDB wins on a tag collision.
            if (bus.cdb_valid && entries_q[bus.cdb_tag].busy) begin
                entries_d[bus.cdb_tag].ready     = 1'b1;
                entries_d[bus.cdb_tag].value     = bus.cdb_value;
                entries_d[bus.cdb_tag].act_taken = bus.cdb_branch_taken;
            end
            if (retire) begin
                entries_d[head].busy  = 1'b0;
                entries_d[head].ready = 1'b0;
            end
            if (alloc_go) begin
                entries_d[tail].busy       = 1'b1;
                entries_d[tail].ready      = 1'b0;
                entries_d[tail].typ        = rob_type_e'(bus.alloc_type);
                entries_d[tail].dest       = bus.alloc_dest;
                entries_d[tail].pred_taken = bus.alloc_pred_taken;
                entries_d[tail].act_taken  = 1'b0;
            end
            if (flush) begin
                for (int i = 0; i < ROB_DEPTH; i++) begin
                    entries_d[i].busy  = 1'b0;
                    entries_d[i].ready = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ROB_DEPTH; i++) entries_q[i] <= '0;
        end else begin
            for (int i = 0; i < ROB_DEPTH; i++) entries_q[i] <= entries_d[i];
        end
    end

    // Pulses clear every enabled cycle; data fields keep their last retired value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            upd_q      <= 1'b0;
            dest_q     <= '0;
            value_q    <= '0;
            ren_q      <= '0;
            st_q       <= 1'b0;
            st_tag_q   <= '0;
            flush_q    <= 1'b0;
            flush_pc_q <= '0;
        end else if (rdy) begin
            upd_q   <= 1'b0;
            st_q    <= 1'b0;
            flush_q <= 1'b0;
            if (retire) begin
                case (head_ent.typ)
                    ROB_NORMAL, ROB_SIMPLE: begin
                        upd_q   <= 1'b1;
                        dest_q  <= head_ent.dest;
                        value_q <= head_ent.value;
                        ren_q   <= head;
                    end
                    ROB_STORE: begin
                        st_q     <= 1'b1;
                        st_tag_q <= head;
                    end
                    default: begin
                        if (mispredict) begin
                            flush_q    <= 1'b1;
                            flush_pc_q <= head_ent.value;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.alloc_tag             = tail;
    assign bus.rob_full              = full;
    assign bus.register_update_flag  = upd_q;
    assign bus.register_commit_dest  = dest_q;
    assign bus.register_commit_value = value_q;
    assign bus.rename_of_commit_ins  = ren_q;
    assign bus.store_commit          = st_q;
    assign bus.store_commit_tag      = st_tag_q;
    assign bus.rob_flush             = flush_q;
    assign bus.rob_flush_pc          = flush_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: retire order, full/wrap, mispredict flush,
// store/simple commit, rdy hold and asynchronous reset.
module tb_reorder_buffer;
    import rob_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rdy = 1'b1;

    reorder_buffer_if bus ();

    reorder_buffer dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    // {dest[40:36], tag[35:32], value[31:0]} of each expected register update
    logic [40:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alloc_valid       = 1'b0;
        bus.alloc_type        = 2'd0;
        bus.alloc_dest        = 5'd0;
        bus.alloc_pred_taken  = 1'b0;
        bus.simple_ins_commit = 1'b0;
        bus.simple_ins_rename = '0;
        bus.simple_ins_value  = '0;
        bus.cdb_valid         = 1'b0;
        bus.cdb_tag           = '0;
        bus.cdb_value         = '0;
        bus.cdb_branch_taken  = 1'b0;
    endtask

    task automatic do_alloc(input logic [1:0] t, input logic [4:0] d, input logic p);
        bus.alloc_valid      = 1'b1;
        bus.alloc_type       = t;
        bus.alloc_dest       = d;
        bus.alloc_pred_taken = p;
        tick();
        bus.alloc_valid      = 1'b0;
    endtask

    task automatic do_cdb(input logic [TAG_W-1:0] tag, input logic [31:0] v, input logic tk);
        bus.cdb_valid        = 1'b1;
        bus.cdb_tag          = tag;
        bus.cdb_value        = v;
        bus.cdb_branch_taken = tk;
        tick();
        bus.cdb_valid        = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        check("rst_flag", 32'(bus.register_update_flag), 32'd0);
        check("rst_alloc_tag", 32'(bus.alloc_tag), 32'd0);
        tick();
        rst = 1'b1;
    endtask

    task automatic sb_step();
        logic [40:0] e;
        if (bus.register_update_flag) begin
            if (exp_q.size() == 0) begin
                check("sb_spurious_update", 32'(bus.register_update_flag), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sb_dest", 32'(bus.register_commit_dest), 32'(e[40:36]));
                check("sb_tag", 32'(bus.rename_of_commit_ins), 32'(e[35:32]));
                check("sb_value", bus.register_commit_value, e[31:0]);
            end
        end
    endtask

    initial begin
        int first;
        int last;
        idle_inputs();
        tick();
        tick();
        check("reset_flag", 32'(bus.register_update_flag), 32'd0);
        check("reset_store", 32'(bus.store_commit), 32'd0);
        check("reset_flush", 32'(bus.rob_flush), 32'd0);
        check("reset_full", 32'(bus.rob_full), 32'd0);
        check("reset_alloc_tag", 32'(bus.alloc_tag), 32'd0);
        check("reset_value", bus.register_commit_value, 32'd0);
        rst = 1'b1;

        // Basic retire
        do_alloc(ROB_NORMAL, 5'd5, 1'b0);
        check("t1_alloc_tag", 32'(bus.alloc_tag), 32'd1);
        do_cdb(4'd0, 32'h1234, 1'b0);
        check("t1_no_bypass", 32'(bus.register_update_flag), 32'd0);
        tick();
        check("t1_flag", 32'(bus.register_update_flag), 32'd1);
        check("t1_dest", 32'(bus.register_commit_dest), 32'd5);
        check("t1_value", bus.register_commit_value, 32'h1234);
        check("t1_tag", 32'(bus.rename_of_commit_ins), 32'd0);
        tick();
        check("t1_pulse_end", 32'(bus.register_update_flag), 32'd0);

        // Out-of-order writeback, in-order retire
        do_reset();
        for (int i = 0; i < 3; i++) do_alloc(ROB_NORMAL, 5'(10 + i), 1'b0);
        do_cdb(4'd2, 32'h22, 1'b0);
        check("t2_wait2", 32'(bus.register_update_flag), 32'd0);
        do_cdb(4'd1, 32'h11, 1'b0);
        check("t2_wait1", 32'(bus.register_update_flag), 32'd0);
        exp_q.push_back({5'd10, 4'd0, 32'h10});
        exp_q.push_back({5'd11, 4'd1, 32'h11});
        exp_q.push_back({5'd12, 4'd2, 32'h22});
        do_cdb(4'd0, 32'h10, 1'b0);
        first = -1;
        last  = -1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.register_update_flag) begin
                if (first < 0) first = i;
                last = i;
            end
            sb_step();
        end
        check("t2_all_retired", 32'(exp_q.size()), 32'd0);
        check("t2_first_cycle", 32'(first), 32'd0);
        check("t2_consecutive", 32'(last), 32'd2);

        // Full, refused allocation, wrap-around
        do_reset();
        for (int i = 0; i < 16; i++) do_alloc(ROB_NORMAL, 5'(i + 1), 1'b0);
        check("t3_full", 32'(bus.rob_full), 32'd1);
        check("t3_tail_wrap", 32'(bus.alloc_tag), 32'd0);
        do_alloc(ROB_NORMAL, 5'd31, 1'b0);
        check("t3_17th_full", 32'(bus.rob_full), 32'd1);
        check("t3_17th_tag", 32'(bus.alloc_tag), 32'd0);
        do_cdb(4'd0, 32'hA0, 1'b0);
        exp_q.push_back({5'd1, 4'd0, 32'hA0});
        tick();
        sb_step();
        check("t3_retired0", 32'(exp_q.size()), 32'd0);
        check("t3_not_full", 32'(bus.rob_full), 32'd0);
        check("t3_reuse_tag", 32'(bus.alloc_tag), 32'd0);
        do_alloc(ROB_NORMAL, 5'd20, 1'b0);
        check("t3_full_again", 32'(bus.rob_full), 32'd1);
        check("t3_tag_after", 32'(bus.alloc_tag), 32'd1);
        do_cdb(4'd1, 32'hA1, 1'b0);
        exp_q.push_back({5'd2, 4'd1, 32'hA1});
        bus.alloc_valid = 1'b1;
        bus.alloc_type  = ROB_NORMAL;
        bus.alloc_dest  = 5'd30;
        tick();
        bus.alloc_valid = 1'b0;
        sb_step();
        check("t3_retired1", 32'(exp_q.size()), 32'd0);
        check("t3_refused_tag", 32'(bus.alloc_tag), 32'd1);
        check("t3_refused_full", 32'(bus.rob_full), 32'd0);
        for (int k = 2; k < 16; k++) begin
            exp_q.push_back({5'(k + 1), 4'(k), 32'hA0 + 32'(k)});
            do_cdb(4'(k), 32'hA0 + 32'(k), 1'b0);
            sb_step();
        end
        exp_q.push_back({5'd20, 4'd0, 32'hB0});
        do_cdb(4'd0, 32'hB0, 1'b0);
        sb_step();
        for (int i = 0; i < 4; i++) begin
            tick();
            sb_step();
        end
        check("t3_wrap_drained", 32'(exp_q.size()), 32'd0);
        check("t3_end_tag", 32'(bus.alloc_tag), 32'd1);

        // Mispredict flush
        do_reset();
        do_alloc(ROB_BRANCH, 5'd0, 1'b0);
        for (int i = 1; i < 4; i++) do_alloc(ROB_NORMAL, 5'(i), 1'b0);
        for (int i = 1; i < 4; i++) do_cdb(4'(i), 32'h100 + 32'(i), 1'b0);
        do_cdb(4'd0, 32'h80, 1'b1);
        bus.alloc_valid = 1'b1;
        bus.alloc_type  = ROB_NORMAL;
        bus.alloc_dest  = 5'd9;
        tick();
        bus.alloc_valid = 1'b0;
        check("t4_flush", 32'(bus.rob_flush), 32'd1);
        check("t4_flush_pc", bus.rob_flush_pc, 32'h80);
        check("t4_no_update", 32'(bus.register_update_flag), 32'd0);
        check("t4_tag_reset", 32'(bus.alloc_tag), 32'd0);
        tick();
        check("t4_flush_end", 32'(bus.rob_flush), 32'd0);
        check("t4_no_update_b", 32'(bus.register_update_flag), 32'd0);
        tick();
        check("t4_no_update_c", 32'(bus.register_update_flag), 32'd0);
        do_alloc(ROB_BRANCH, 5'd0, 1'b1);
        do_cdb(4'd0, 32'h40, 1'b1);
        tick();
        check("t4_good_no_flush", 32'(bus.rob_flush), 32'd0);
        check("t4_good_tag", 32'(bus.alloc_tag), 32'd1);
        do_alloc(ROB_NORMAL, 5'd6, 1'b0);
        do_cdb(4'd1, 32'h61, 1'b0);
        tick();
        check("t4_after_branch_flag", 32'(bus.register_update_flag), 32'd1);
        check("t4_after_branch_tag", 32'(bus.rename_of_commit_ins), 32'd1);
        check("t4_after_branch_val", bus.register_commit_value, 32'h61);

        // Store and simple completing together, then CDB/simple collision
        do_reset();
        do_alloc(ROB_STORE, 5'd0, 1'b0);
        do_alloc(ROB_SIMPLE, 5'd7, 1'b0);
        bus.simple_ins_commit = 1'b1;
        bus.simple_ins_rename = 4'd1;
        bus.simple_ins_value  = 32'd7;
        bus.cdb_valid         = 1'b1;
        bus.cdb_tag           = 4'd0;
        bus.cdb_value         = 32'h99;
        tick();
        idle_inputs();
        tick();
        check("t5_store", 32'(bus.store_commit), 32'd1);
        check("t5_store_tag", 32'(bus.store_commit_tag), 32'd0);
        check("t5_store_no_upd", 32'(bus.register_update_flag), 32'd0);
        tick();
        check("t5_simple_flag", 32'(bus.register_update_flag), 32'd1);
        check("t5_simple_val", bus.register_commit_value, 32'd7);
        check("t5_simple_dest", 32'(bus.register_commit_dest), 32'd7);
        check("t5_simple_tag", 32'(bus.rename_of_commit_ins), 32'd1);
        check("t5_store_end", 32'(bus.store_commit), 32'd0);
        do_alloc(ROB_NORMAL, 5'd9, 1'b0);
        bus.simple_ins_commit = 1'b1;
        bus.simple_ins_rename = 4'd2;
        bus.simple_ins_value  = 32'h55;
        bus.cdb_valid         = 1'b1;
        bus.cdb_tag           = 4'd2;
        bus.cdb_value         = 32'h66;
        tick();
        idle_inputs();
        tick();
        check("t5_cdb_wins_flag", 32'(bus.register_update_flag), 32'd1);
        check("t5_cdb_wins_val", bus.register_commit_value, 32'h66);

        // Writeback to idle entry, rdy hold, mid-stream reset
        do_reset();
        do_cdb(4'd0, 32'hDEAD, 1'b0);
        do_alloc(ROB_NORMAL, 5'd4, 1'b0);
        tick();
        tick();
        check("t6_nonbusy_ignored", 32'(bus.register_update_flag), 32'd0);
        do_cdb(4'd0, 32'h44, 1'b0);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_rdy_hold", 32'(bus.register_update_flag), 32'd0);
        end
        rdy = 1'b1;
        tick();
        check("t6_resume_flag", 32'(bus.register_update_flag), 32'd1);
        check("t6_resume_val", bus.register_commit_value, 32'h44);
        rdy = 1'b0;
        tick();
        check("t6_pulse_held", 32'(bus.register_update_flag), 32'd1);
        rdy = 1'b1;
        tick();
        check("t6_pulse_end", 32'(bus.register_update_flag), 32'd0);
        do_alloc(ROB_NORMAL, 5'd2, 1'b0);
        do_alloc(ROB_NORMAL, 5'd3, 1'b0);
        do_cdb(4'd1, 32'h77, 1'b0);
        tick();
        check("t6_pre_reset_flag", 32'(bus.register_update_flag), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("t6_async_flag", 32'(bus.register_update_flag), 32'd0);
        check("t6_async_val", bus.register_commit_value, 32'd0);
        check("t6_async_tag", 32'(bus.alloc_tag), 32'd0);
        tick();
        rst = 1'b1;
        do_alloc(ROB_NORMAL, 5'd1, 1'b0);
        check("t6_post_tag", 32'(bus.alloc_tag), 32'd1);
        do_cdb(4'd0, 32'h5, 1'b0);
        tick();
        check("t6_post_retire_tag", 32'(bus.rename_of_commit_ins), 32'd0);
        check("t6_post_retire_val", bus.register_commit_value, 32'h5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
